// File: rtl/cam_i2c_write_sequencer.sv
// cam_i2c_write_sequencer: turns reg/hi/lo byte triples into I2C write transactions with bounded NACK retry
module cam_i2c_write_sequencer #(
  parameter logic [7:0] CAM0_ADDR = 8'hBA,
  parameter logic [7:0] CAM1_ADDR = 8'h90,
  parameter int MAX_RETRY = 3
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_in_valid,
  input  logic       byte_in_last,
  input  logic       cam_id,
  output logic       ready_for_next_byte,
  output logic [1:0] i2c_cmd,
  output logic [7:0] i2c_byte,
  output logic       i2c_cmd_valid,
  input  logic       i2c_cmd_ready,
  input  logic       i2c_done,
  input  logic       i2c_ack,
  output logic       busy,
  output logic [1:0] error_code,
  output logic [7:0] err_reg_addr,
  output logic [4:0] writes_done
);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [AW-1:0] MAXR = AW'(MAX_RETRY);
  typedef enum logic [3:0] {IDLE, FETCH, START, REG, HI, LO, STOP, CHECK, DRAIN} state_t;
  state_t state_q, state_d;
  logic cam_q, cam_d, last_q, last_d, nack_q, nack_d, sent_q, sent_d;
  logic [7:0] reg_q, reg_d, hi_q, hi_d, lo_q, lo_d, err_addr_q, err_addr_d;
  logic [1:0] fill_q, fill_d, err_q, err_d;
  logic [AW-1:0] att_q, att_d;
  logic [4:0] wd_q, wd_d;
  logic cmd_st, accept, hs, done;
  assign cmd_st = state_q inside {START, REG, HI, LO, STOP};
  assign ready_for_next_byte = !rst && (state_q inside {IDLE, FETCH, DRAIN});
  assign accept = byte_in_valid && ready_for_next_byte;
  assign i2c_cmd_valid = cmd_st && !sent_q;
  assign hs = i2c_cmd_valid && i2c_cmd_ready;
  // a done pulse only counts while a command is outstanding, including the handshake cycle
  assign done = i2c_done && (sent_q || hs);
  assign i2c_cmd = state_q == START ? 2'b01 : state_q == STOP ? 2'b11 : cmd_st ? 2'b10 : 2'b00;
  assign i2c_byte = state_q == START ? (cam_q ? CAM1_ADDR : CAM0_ADDR) :
                    state_q == REG ? reg_q : state_q == HI ? hi_q : state_q == LO ? lo_q : 8'h00;
  assign busy = state_q != IDLE;
  assign error_code = err_q;
  assign err_reg_addr = err_addr_q;
  assign writes_done = wd_q;
  always_comb begin
    state_d = state_q;
    cam_d = cam_q;
    last_d = last_q;
    nack_d = nack_q;
    sent_d = (sent_q || hs) && !done;
    reg_d = reg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    err_addr_d = err_addr_q;
    fill_d = fill_q;
    err_d = err_q;
    att_d = att_q;
    wd_d = wd_q;
    case (state_q)
      IDLE: if (accept) begin
        cam_d = cam_id;
        wd_d = 5'd0;
        reg_d = byte_in;
        fill_d = 2'd1;
        last_d = byte_in_last;
        err_d = byte_in_last ? 2'b10 : 2'b00;
        err_addr_d = byte_in_last ? byte_in : 8'h00;
        state_d = byte_in_last ? IDLE : FETCH;
      end
      FETCH: if (accept) begin
        last_d = byte_in_last;
        fill_d = fill_q + 2'd1;
        reg_d = fill_q == 2'd0 ? byte_in : reg_q;
        hi_d = fill_q == 2'd1 ? byte_in : hi_q;
        lo_d = fill_q == 2'd2 ? byte_in : lo_q;
        if (byte_in_last && fill_q != 2'd2) begin
          err_d = 2'b10;
          err_addr_d = fill_q == 2'd0 ? byte_in : reg_q;
          state_d = IDLE;
        end else if (fill_q == 2'd2) begin
          att_d = AW'(1);
          nack_d = 1'b0;
          state_d = START;
        end
      end
      START, REG, HI, LO: if (done) begin
        nack_d = !i2c_ack;
        state_d = i2c_ack ? state_t'(state_q + 4'd1) : STOP;
      end
      STOP: if (done) state_d = CHECK;
      CHECK: if (!nack_q) begin
        wd_d = &wd_q ? wd_q : wd_q + 5'd1;
        fill_d = 2'd0;
        state_d = last_q ? IDLE : FETCH;
      end else if (att_q < MAXR) begin
        att_d = att_q + AW'(1);
        nack_d = 1'b0;
        state_d = START;
      end else begin
        err_d = 2'b01;
        err_addr_d = reg_q;
        state_d = last_q ? IDLE : DRAIN;
      end
      DRAIN: if (accept && byte_in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q <= IDLE;
      cam_q <= 1'b0;
      last_q <= 1'b0;
      nack_q <= 1'b0;
      sent_q <= 1'b0;
      reg_q <= 8'h00;
      hi_q <= 8'h00;
      lo_q <= 8'h00;
      err_addr_q <= 8'h00;
      fill_q <= 2'd0;
      err_q <= 2'b00;
      att_q <= '0;
      wd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cam_q <= cam_d;
      last_q <= last_d;
      nack_q <= nack_d;
      sent_q <= sent_d;
      reg_q <= reg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      err_addr_q <= err_addr_d;
      fill_q <= fill_d;
      err_q <= err_d;
      att_q <= att_d;
      wd_q <= wd_d;
    end
  end
endmodule

// File: tb/tb_cam_i2c_write_sequencer.sv
// tb_cam_i2c_write_sequencer: scoreboard bench with a behavioural byte-level I2C engine
module tb_cam_i2c_write_sequencer;
  logic sysClk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic byte_in_valid = 1'b0, byte_in_last = 1'b0, cam_id = 1'b0;
  logic ready_for_next_byte, i2c_cmd_valid, busy;
  logic [1:0] i2c_cmd, error_code;
  logic [7:0] i2c_byte, err_reg_addr;
  logic [4:0] writes_done;
  logic i2c_cmd_ready, i2c_done, i2c_ack;
  int n_cmp = 0, n_fail = 0, cmd_cnt = 0, ready_lat = 0, done_lat = 1;
  logic [9:0] expq[$];
  logic [9:0] mon_e;
  bit ackq[$];

  always #5 sysClk = ~sysClk;

  cam_i2c_write_sequencer dut (
    .sysClk(sysClk), .rst(rst), .byte_in(byte_in), .byte_in_valid(byte_in_valid),
    .byte_in_last(byte_in_last), .cam_id(cam_id), .ready_for_next_byte(ready_for_next_byte),
    .i2c_cmd(i2c_cmd), .i2c_byte(i2c_byte), .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd_ready(i2c_cmd_ready), .i2c_done(i2c_done), .i2c_ack(i2c_ack), .busy(busy),
    .error_code(error_code), .err_reg_addr(err_reg_addr), .writes_done(writes_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [1:0] c, input logic [7:0] b);
    expq.push_back({c, b});
  endtask

  task automatic exp_triple(input logic [7:0] dev, input logic [7:0] r, input logic [7:0] h, input logic [7:0] l);
    exp_cmd(2'b01, dev);
    exp_cmd(2'b10, r);
    exp_cmd(2'b10, h);
    exp_cmd(2'b10, l);
    exp_cmd(2'b11, 8'h00);
  endtask

  // called at a negedge; returns at the negedge following acceptance of the final byte
  task automatic feed(input logic [7:0] b[$], input bit cam);
    for (int i = 0; i < b.size(); i++) begin
      int n = 0;
      byte_in = b[i];
      byte_in_last = (i == b.size() - 1);
      cam_id = cam;
      byte_in_valid = 1'b1;
      #1;
      while (!ready_for_next_byte && n < 3000) begin
        @(negedge sysClk);
        #1;
        n++;
      end
      if (n >= 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL feed_timeout: byte %0d never accepted, required acceptance", i);
        byte_in_valid = 1'b0;
        return;
      end
      @(negedge sysClk);
    end
    byte_in_valid = 1'b0;
    byte_in_last = 1'b0;
  endtask

  task automatic finish_seq(input string tag, input logic [4:0] wd, input logic [1:0] ec, input logic [7:0] ea);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge sysClk);
      n++;
    end
    check({tag, "_busy"}, busy, 0);
    repeat (5) @(negedge sysClk);
    check({tag, "_writes_done"}, writes_done, wd);
    check({tag, "_error_code"}, error_code, ec);
    check({tag, "_err_reg_addr"}, err_reg_addr, ea);
    check({tag, "_pending_cmds"}, expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready_for_next_byte, 0);
    check({tag, "_cmd"}, i2c_cmd, 0);
    check({tag, "_byte"}, i2c_byte, 0);
    check({tag, "_cmd_valid"}, i2c_cmd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error_code"}, error_code, 0);
    check({tag, "_err_reg_addr"}, err_reg_addr, 0);
    check({tag, "_writes_done"}, writes_done, 0);
  endtask

  // I2C byte engine: configurable ready and done latency, ACK per command from ackq (default ACK)
  initial begin
    int cnt, rwait;
    bit pend, a;
    cnt = 0;
    rwait = 0;
    pend = 1'b0;
    a = 1'b1;
    i2c_cmd_ready = 1'b0;
    i2c_done = 1'b0;
    i2c_ack = 1'b0;
    forever begin
      @(negedge sysClk);
      i2c_done = 1'b0;
      i2c_ack = 1'b0;
      i2c_cmd_ready = 1'b0;
      if (rst) begin
        pend = 1'b0;
        rwait = 0;
      end else if (pend) begin
        if (cnt == 0) begin
          i2c_done = 1'b1;
          i2c_ack = a;
          pend = 1'b0;
        end else cnt--;
      end else if (i2c_cmd_valid) begin
        if (rwait < ready_lat) rwait++;
        else begin
          rwait = 0;
          i2c_cmd_ready = 1'b1;
          a = ackq.size() > 0 ? ackq.pop_front() : 1'b1;
          if (done_lat == 0) begin
            i2c_done = 1'b1;
            i2c_ack = a;
          end else begin
            pend = 1'b1;
            cnt = done_lat - 1;
          end
        end
      end
    end
  end

  // monitor: every command handshake is checked against the scoreboard queue
  initial forever begin
    @(negedge sysClk);
    #2;
    if (!rst && i2c_cmd_valid) begin
      check("ready_while_cmd", ready_for_next_byte, 0);
      if (i2c_cmd_ready) begin
        cmd_cnt++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_cmd: got cmd %0d byte %02h, required no command", i2c_cmd, i2c_byte);
        end else begin
          mon_e = expq.pop_front();
          check("cmd", i2c_cmd, mon_e[9:8]);
          if (mon_e[9:8] != 2'b11) check("cmd_byte", i2c_byte, mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[$];
    int base, n;
    repeat (3) @(negedge sysClk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge sysClk);
    check("idle_ready", ready_for_next_byte, 1);

    done_lat = 0;
    ready_lat = 0;
    exp_triple(8'hBA, 8'h0D, 8'h00, 8'h01);
    seq = '{8'h0D, 8'h00, 8'h01};
    feed(seq, 1'b0);
    finish_seq("single", 5'd1, 2'b00, 8'h00);

    done_lat = 2;
    ready_lat = 1;
    seq = '{8'h09, 8'h00, 8'h10, 8'h0C, 8'h00, 8'h00, 8'h2B, 8'h00, 8'h08, 8'h2C, 8'h00, 8'h08,
            8'h2D, 8'h00, 8'h08, 8'h2E, 8'h00, 8'h08, 8'h35, 8'h00, 8'h20};
    for (int t = 0; t < 7; t++) exp_triple(8'h90, seq[3*t], seq[3*t+1], seq[3*t+2]);
    feed(seq, 1'b1);
    finish_seq("shutter", 5'd7, 2'b00, 8'h00);

    done_lat = 1;
    ready_lat = 0;
    ackq = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_cmd(2'b01, 8'hBA);
    exp_cmd(2'b10, 8'h09);
    exp_cmd(2'b10, 8'h12);
    exp_cmd(2'b11, 8'h00);
    exp_triple(8'hBA, 8'h09, 8'h12, 8'h34);
    seq = '{8'h09, 8'h12, 8'h34};
    feed(seq, 1'b0);
    finish_seq("retry", 5'd1, 2'b00, 8'h00);

    ackq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      exp_cmd(2'b01, 8'h90);
      exp_cmd(2'b11, 8'h00);
    end
    seq = '{8'h22, 8'hAA, 8'h55, 8'h30, 8'h01, 8'h02};
    feed(seq, 1'b1);
    finish_seq("nack_exhaust", 5'd0, 2'b01, 8'h22);

    seq = '{8'h0D, 8'h00};
    feed(seq, 1'b0);
    finish_seq("truncated", 5'd0, 2'b10, 8'h0D);

    done_lat = 30;
    base = cmd_cnt;
    n = 0;
    exp_triple(8'hBA, 8'h40, 8'h41, 8'h42);
    seq = '{8'h40, 8'h41, 8'h42};
    feed(seq, 1'b0);
    while (cmd_cnt < base + 3 && n < 3000) begin
      @(negedge sysClk);
      #3;
      n++;
    end
    check("reset_test_hi_issued", cmd_cnt - base, 3);
    repeat (3) @(negedge sysClk);
    rst = 1'b1;
    @(negedge sysClk);
    check_reset_outputs("mid_reset");
    expq.delete();
    ackq.delete();
    @(negedge sysClk);
    rst = 1'b0;
    @(negedge sysClk);

    done_lat = 1;
    exp_triple(8'hBA, 8'h20, 8'h01, 8'h02);
    seq = '{8'h20, 8'h01, 8'h02};
    feed(seq, 1'b0);
    finish_seq("post_reset", 5'd1, 2'b00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
